dm_bridge: RTL and testbench
============================

Name: dm_bridge

Overview:
- Sits directly downstream of the single-cycle RVCPU data-memory port.
- Consumes dm_rd_ctrl, dm_wr_ctrl, dm_addr and dm_din, and returns dm_dout.
- Converts each CPU byte/half/word/double access into one 8-byte-aligned request, with byte strobes, on a req/ack memory bus.
- Holds the CPU via stall, which drives the PC stall input, until the access completes; also handles load extension, misalignment and bus timeout.

Parameters:
- TIMEOUT, 255: maximum BUSY cycles waiting for mem_ack before aborting with bus_err.
- ADDR_W, 64: width of dm_addr and mem_addr.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- dm_rd_ctrl  in  3  load type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD.
- dm_wr_ctrl  in  3  store type: 0 none, 1 SB, 2 SH, 3 SW, 4 SD; 5-7 treated as none.
- dm_addr  in  ADDR_W  byte address (CPU ALU result).
- dm_din  in  64  store data, low-aligned.
- dm_dout  out  64  load result, extended per dm_rd_ctrl.
- stall  out  1  holds CPU PC and instruction while the access is in flight.
- misalign  out  1  access violates natural alignment (combinational).
- bus_err  out  1  one-cycle pulse when an access is aborted by timeout.
- mem_req  out  1  request valid (registered).
- mem_we  out  1  1 for write, 0 for read (registered).
- mem_addr  out  ADDR_W  dm_addr with bits [2:0] cleared (registered).
- mem_wstrb  out  8  byte-lane enables for writes; 0 for reads.
- mem_wdata  out  64  store data replicated into the addressed lanes.
- mem_ack  in  1  memory completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  64  read data, 8-byte aligned.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0.
  - Captured data=0; timeout counter=0; bus_err=0.
  - stall=0 and dm_dout=0 while rst is low.
- Definitions:
  - access = (dm_wr_ctrl in 1..4) OR (dm_rd_ctrl != 0).
  - A write takes precedence when both are nonzero; dm_rd_ctrl is then ignored.
- Alignment rules:
  - Half accesses require addr[0]=0.
  - Word accesses require addr[1:0]=0.
  - Double accesses require addr[2:0]=0.
  - Byte accesses are always aligned.
- IDLE state:
  - access and misaligned: misalign=1 and stall=0 combinationally, no request, dm_dout=0; the instruction retires that cycle with the write dropped.
  - access and aligned: stall=1 combinationally. Next edge: go to BUSY, register mem_req=1, mem_we, mem_addr, mem_wstrb, mem_wdata, and clear the counter.
  - No access: stall=0, dm_dout=0.
- BUSY state:
  - stall=1; mem_req and all mem_* outputs held stable.
  - mem_ack=1: capture mem_rdata, drop mem_req at the edge, go to DONE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without ack: drop mem_req, capture 0, pulse bus_err for the DONE cycle, go to DONE.
- DONE state:
  - stall=0; dm_dout = extended captured data; exactly one cycle; then IDLE.
  - The CPU writes back and advances PC on this edge.
- Latency: minimum 3 cycles per memory instruction (IDLE, BUSY with ack, DONE); each extra BUSY cycle adds one.
- mem_ack in IDLE or DONE is ignored.
- Load extraction:
  - shifted = captured >> (8*dm_addr[2:0]).
  - LB/LH/LW sign-extend from bit 7/15/31; LBU/LHU/LWU zero-extend; LD passes shifted unchanged.
- Store lanes (off = dm_addr[2:0]):
  - SB: wstrb = 1<<off; wdata = dm_din[7:0] replicated x8.
  - SH: wstrb = 3<<off; wdata = dm_din[15:0] replicated x4.
  - SW: wstrb = 0x0F<<off; wdata = dm_din[31:0] replicated x2.
  - SD: wstrb = 0xFF; wdata = dm_din.
- Inputs are guaranteed stable while stall=1 because the CPU is frozen. The bridge uses live dm_addr and dm_rd_ctrl in DONE for extraction.

Decomposition:
- Package rvcpu_mem_pkg:
  - rd_ctrl/wr_ctrl encoding constants (LB..LD, SB..SD, NONE).
  - State enum IDLE/BUSY/DONE.
  - Function returning access size in bytes.
- Sub-module dm_lane (combinational):
  - Store side: alignment check, wstrb and wdata generation.
  - Load side: extraction and extension.
  - dm_bridge keeps the FSM, counter and registers.

Test Plan:
- SB: dm_wr_ctrl=1, addr=0x1003, din=0xAB, ack on the 1st BUSY cycle -> mem_addr=0x1000, wstrb=0x08, wdata=0xABAB..AB, mem_we=1; stall high for exactly 2 cycles.
- LB sign/LBU zero: addr=0x2005, rdata=0x0000_80FF_0000_0000 (byte5=0x80) -> LB dm_dout=0xFFFF_FFFF_FFFF_FF80 in DONE; LBU dm_dout=0x80.
- LW misaligned: rd_ctrl=5, addr=0x3002 -> misalign=1, stall=0, mem_req stays 0, dm_dout=0 in the same cycle.
- Timeout with TIMEOUT=4 and ack never asserted -> mem_req high for 4 cycles, then bus_err=1 for one cycle, dm_dout=0, return to IDLE.
- Reset mid-BUSY: assert rst=0 asynchronously between edges -> mem_req=0 and stall=0 immediately; a late ack after release is ignored; state is IDLE.
- Back-to-back SD (addr 0x10) then LD (addr 0x10) with a memory model -> LD returns the stored 64-bit value; 6 cycles total.

Source files
------------

// File: rtl/rvcpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// rvcpu_mem_pkg
// Shared definitions for the RVCPU data-memory bridge:
//   - dm_rd_ctrl / dm_wr_ctrl encodings
//   - bridge FSM state type
//   - access_bytes(): size in bytes of the access selected by the control codes
// -----------------------------------------------------------------------------
package rvcpu_mem_pkg;

    // Load types carried on dm_rd_ctrl
    localparam logic [2:0] RD_NONE = 3'd0;
    localparam logic [2:0] RD_LB   = 3'd1;
    localparam logic [2:0] RD_LBU  = 3'd2;
    localparam logic [2:0] RD_LH   = 3'd3;
    localparam logic [2:0] RD_LHU  = 3'd4;
    localparam logic [2:0] RD_LW   = 3'd5;
    localparam logic [2:0] RD_LWU  = 3'd6;
    localparam logic [2:0] RD_LD   = 3'd7;

    // Store types carried on dm_wr_ctrl; codes 5-7 behave as WR_NONE
    localparam logic [2:0] WR_NONE = 3'd0;
    localparam logic [2:0] WR_SB   = 3'd1;
    localparam logic [2:0] WR_SH   = 3'd2;
    localparam logic [2:0] WR_SW   = 3'd3;
    localparam logic [2:0] WR_SD   = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // A valid store wins over any load code; 0 means no access.
    function automatic logic [3:0] access_bytes(input logic [2:0] rd_ctrl,
                                                input logic [2:0] wr_ctrl);
        logic [3:0] n;
        case (wr_ctrl)
            WR_SB:   n = 4'd1;
            WR_SH:   n = 4'd2;
            WR_SW:   n = 4'd4;
            WR_SD:   n = 4'd8;
            default: begin
                case (rd_ctrl)
                    RD_LB, RD_LBU: n = 4'd1;
                    RD_LH, RD_LHU: n = 4'd2;
                    RD_LW, RD_LWU: n = 4'd4;
                    RD_LD:         n = 4'd8;
                    default:       n = 4'd0;
                endcase
            end
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dm_bridge_if.sv
// -----------------------------------------------------------------------------
// dm_bridge_if
// req/ack memory bus between dm_bridge (master) and the data memory (slave).
//   mem_req   request valid            mem_we    1 = write, 0 = read
//   mem_addr  8-byte aligned address   mem_wstrb byte-lane enables (writes)
//   mem_wdata lane-replicated data     mem_ack   completion (rdata valid)
//   mem_rdata 8-byte aligned read data
// -----------------------------------------------------------------------------
interface dm_bridge_if #(
    parameter int ADDR_W = 64
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wstrb;
    logic [63:0]       mem_wdata;
    logic              mem_ack;
    logic [63:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dm_lane.sv
// -----------------------------------------------------------------------------
// dm_lane
// Purely combinational byte-lane logic for dm_bridge.
//   rd_ctrl, wr_ctrl  CPU load/store codes
//   off               dm_addr[2:0], byte offset inside the 8-byte word
//   din               low-aligned store data
//   captured          8-byte word returned by memory
//   is_wr / access    decoded store / any-access flags
//   misalign          access breaks natural alignment
//   wstrb / wdata     write lanes and lane-replicated store data
//   load_data         extracted and extended load result
// -----------------------------------------------------------------------------
module dm_lane
    import rvcpu_mem_pkg::*;
(
    input  logic [2:0]  rd_ctrl,
    input  logic [2:0]  wr_ctrl,
    input  logic [2:0]  off,
    input  logic [63:0] din,
    input  logic [63:0] captured,
    output logic        is_wr,
    output logic        access,
    output logic        misalign,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata,
    output logic [63:0] load_data
);
    logic [3:0]  nbytes;
    logic [63:0] shifted;

    always_comb begin
        is_wr  = (wr_ctrl >= WR_SB) && (wr_ctrl <= WR_SD);
        access = is_wr || (rd_ctrl != RD_NONE);
        nbytes = access_bytes(rd_ctrl, wr_ctrl);

        // nbytes is 0 for no access, so misalign is already gated by access
        case (nbytes)
            4'd2:    misalign = off[0];
            4'd4:    misalign = (off[1:0] != 2'b00);
            4'd8:    misalign = (off != 3'b000);
            default: misalign = 1'b0;
        endcase

        wstrb = 8'h00;
        wdata = 64'h0;
        case (wr_ctrl)
            WR_SB: begin
                wstrb = 8'h01 << off;
                wdata = {8{din[7:0]}};
            end
            WR_SH: begin
                wstrb = 8'h03 << off;
                wdata = {4{din[15:0]}};
            end
            WR_SW: begin
                wstrb = 8'h0F << off;
                wdata = {2{din[31:0]}};
            end
            WR_SD: begin
                wstrb = 8'hFF;
                wdata = din;
            end
            default: ;
        endcase

        shifted = captured >> {off, 3'b000};
        case (rd_ctrl)
            RD_LB:   load_data = {{56{shifted[7]}},  shifted[7:0]};
            RD_LBU:  load_data = {56'h0,             shifted[7:0]};
            RD_LH:   load_data = {{48{shifted[15]}}, shifted[15:0]};
            RD_LHU:  load_data = {48'h0,             shifted[15:0]};
            RD_LW:   load_data = {{32{shifted[31]}}, shifted[31:0]};
            RD_LWU:  load_data = {32'h0,             shifted[31:0]};
            RD_LD:   load_data = shifted;
            default: load_data = 64'h0;
        endcase
    end
endmodule

// File: rtl/dm_bridge.sv
// -----------------------------------------------------------------------------
// dm_bridge
// Turns single-cycle RVCPU data-memory accesses into one 8-byte aligned
// req/ack bus transaction each, stalling the CPU until completion.
//   clk, rst            clock; asynchronous active-low reset
//   dm_rd_ctrl          load type (0 none, LB..LD)
//   dm_wr_ctrl          store type (0 none, SB..SD, 5-7 none)
//   dm_addr, dm_din     byte address and low-aligned store data
//   dm_dout             extended load result, valid in DONE
//   stall               freezes PC while an access is in flight
//   misalign            combinational alignment violation flag
//   bus_err             one-cycle pulse in DONE after a timeout abort
//   mem                 master side of the memory bus
// FSM: IDLE -> BUSY (request outstanding) -> DONE (one cycle) -> IDLE.
// -----------------------------------------------------------------------------
module dm_bridge
    import rvcpu_mem_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        dm_rd_ctrl,
    input  logic [2:0]        dm_wr_ctrl,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [63:0]       dm_din,
    output logic [63:0]       dm_dout,
    output logic              stall,
    output logic              misalign,
    output logic              bus_err,
    dm_bridge_if.master       mem
);
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [63:0]       cap_q;
    logic              bus_err_q;
    logic              req_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wstrb_q;
    logic [63:0]       wdata_q;

    logic              is_wr, access, lane_misalign;
    logic [7:0]        wstrb_c;
    logic [63:0]       wdata_c, load_c;

    dm_lane u_lane (
        .rd_ctrl   (dm_rd_ctrl),
        .wr_ctrl   (dm_wr_ctrl),
        .off       (dm_addr[2:0]),
        .din       (dm_din),
        .captured  (cap_q),
        .is_wr     (is_wr),
        .access    (access),
        .misalign  (lane_misalign),
        .wstrb     (wstrb_c),
        .wdata     (wdata_c),
        .load_data (load_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        dm_dout = 64'h0;
        case (state_q)
            IDLE: begin
                if (access && !lane_misalign) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem.mem_ack || (cnt_q == CNT_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // A store's completion returns nothing to the register file
                dm_dout = is_wr ? 64'h0 : load_c;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Keep the CPU free while reset is asserted even if it presents an access
        if (!rst) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wstrb_q   <= 8'h00;
            wdata_q   <= 64'h0;
            cap_q     <= 64'h0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (state_d == BUSY) begin
                        req_q   <= 1'b1;
                        we_q    <= is_wr;
                        addr_q  <= {dm_addr[ADDR_W-1:3], 3'b000};
                        wstrb_q <= wstrb_c;
                        wdata_q <= wdata_c;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    if (mem.mem_ack) begin
                        cap_q <= mem.mem_rdata;
                        req_q <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        // Abort: a timed-out load reads back as zero
                        cap_q     <= 64'h0;
                        req_q     <= 1'b0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign misalign      = lane_misalign;
    assign bus_err       = bus_err_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wstrb = wstrb_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_dm_bridge.sv
// -----------------------------------------------------------------------------
// tb_dm_bridge
// Drives CPU-side accesses into dm_bridge while acting as the bus memory.
// Expected outputs come from a byte-addressed reference memory and the
// CPU-level access rules (size, alignment, extension, lane replication).
// -----------------------------------------------------------------------------
module tb_dm_bridge;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  dm_rd_ctrl, dm_wr_ctrl;
    logic [63:0] dm_addr, dm_din, dm_dout;
    logic        stall, misalign, bus_err;

    dm_bridge_if #(.ADDR_W(64)) mem_if ();

    dm_bridge #(.TIMEOUT(TO), .ADDR_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .dm_rd_ctrl (dm_rd_ctrl),
        .dm_wr_ctrl (dm_wr_ctrl),
        .dm_addr    (dm_addr),
        .dm_din     (dm_din),
        .dm_dout    (dm_dout),
        .stall      (stall),
        .misalign   (misalign),
        .bus_err    (bus_err),
        .mem        (mem_if)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Expectations published by the driver, consumed by the compare process
    logic        chk_en, chk_bus, chk_wdata;
    logic        exp_stall, exp_mis, exp_req, exp_berr, exp_we;
    logic [63:0] exp_dout, exp_addr, exp_wdata;
    logic [7:0]  exp_wstrb;

    // Observations for the hand-computed scenario checks
    int          stall_cnt, req_cnt, berr_cnt;
    logic [63:0] last_dout;
    logic        last_mis;
    logic [63:0] last_addr, last_wdata;
    logic [7:0]  last_wstrb;
    logic        last_we;

    // Reference (byte-addressed, CPU view) and physical (8-byte words, bus view)
    logic [7:0]  ref_mem  [logic [63:0]];
    logic [63:0] phys_mem [logic [63:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] rd, input logic [2:0] wr);
        if (wr >= 3'd1 && wr <= 3'd4) return 1 << (int'(wr) - 1);
        if (rd == 3'd0) return 0;
        return 1 << ((int'(rd) - 1) / 2);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [63:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return 8'h00;
    endfunction

    function automatic logic [63:0] phys_rd(input logic [63:0] a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return 64'h0;
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] rd, input logic [63:0] a);
        int          n;
        logic [63:0] v;
        logic        fill;
        n = size_of(rd, 3'd0);
        v = 64'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_byte(a + 64'(i));
        fill = (rd == 3'd1 || rd == 3'd3 || rd == 3'd5) && v[8*n-1];
        for (int i = n; i < 8; i++) v[8*i +: 8] = fill ? 8'hFF : 8'h00;
        return v;
    endfunction

    task automatic preload(input logic [63:0] a, input logic [63:0] w);
        phys_mem[a] = w;
        for (int i = 0; i < 8; i++) ref_mem[a + 64'(i)] = w[8*i +: 8];
    endtask

    task automatic set_idle_exp();
        exp_stall = 1'b0; exp_mis = 1'b0; exp_req = 1'b0;
        exp_berr  = 1'b0; exp_dout = 64'h0; chk_bus = 1'b0; chk_wdata = 1'b0;
    endtask

    task automatic reset_obs();
        stall_cnt = 0; req_cnt = 0; berr_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (stall === 1'b1)          stall_cnt++;
        if (mem_if.mem_req === 1'b1) req_cnt++;
        if (bus_err === 1'b1)        berr_cnt++;
        if (stall !== 1'b1)          last_dout = dm_dout;
        last_mis = misalign;
        if (chk_en) begin
            check("stall",    64'(stall),          64'(exp_stall));
            check("misalign", 64'(misalign),       64'(exp_mis));
            check("mem_req",  64'(mem_if.mem_req), 64'(exp_req));
            check("bus_err",  64'(bus_err),        64'(exp_berr));
            check("dm_dout",  dm_dout,             exp_dout);
            if (chk_bus) begin
                check("mem_we",    64'(mem_if.mem_we),    64'(exp_we));
                check("mem_addr",  mem_if.mem_addr,       exp_addr);
                check("mem_wstrb", 64'(mem_if.mem_wstrb), 64'(exp_wstrb));
                if (chk_wdata) check("mem_wdata", mem_if.mem_wdata, exp_wdata);
            end
        end
    end

    // One CPU instruction, entered and left just after a rising edge.
    // ack_at: BUSY cycle (1-based) in which memory acks; 0 = never (timeout).
    task automatic do_access(input logic [2:0] rd, input logic [2:0] wr,
                             input logic [63:0] a, input logic [63:0] d,
                             input int ack_at, output int ncyc);
        int          sz, off, nb;
        bit          wrx, acc, mis, tmo;
        logic [63:0] word;
        wrx = (wr >= 3'd1 && wr <= 3'd4);
        sz  = size_of(rd, wr);
        acc = (sz != 0);
        off = int'(a[2:0]);
        mis = acc && ((off % sz) != 0);
        tmo = (ack_at == 0);
        nb  = tmo ? TO : ack_at;

        dm_rd_ctrl = rd; dm_wr_ctrl = wr; dm_addr = a; dm_din = d;
        chk_en = 1'b1;
        set_idle_exp();
        exp_stall = acc && !mis;
        exp_mis   = mis;
        // Stray acks outside BUSY must be ignored
        mem_if.mem_ack   = 1'($urandom_range(0, 1));
        mem_if.mem_rdata = {$urandom, $urandom};
        ncyc = 1;
        @(posedge clk); #1;

        if (acc && !mis) begin
            exp_stall = 1'b1; exp_req = 1'b1; chk_bus = 1'b1; chk_wdata = wrx;
            exp_we    = wrx;
            exp_addr  = a & ~64'h7;
            exp_wstrb = 8'h00;
            exp_wdata = 64'h0;
            if (wrx) begin
                for (int i = 0; i < 8; i++) begin
                    exp_wdata[8*i +: 8] = d[8*(i % sz) +: 8];
                    if (i >= off && i < off + sz) exp_wstrb[i] = 1'b1;
                end
            end
            for (int k = 1; k <= nb; k++) begin
                mem_if.mem_ack   = !tmo && (k == nb);
                mem_if.mem_rdata = {$urandom, $urandom};
                if (mem_if.mem_ack) begin
                    last_addr = mem_if.mem_addr; last_wstrb = mem_if.mem_wstrb;
                    last_wdata = mem_if.mem_wdata; last_we = mem_if.mem_we;
                    word = phys_rd(mem_if.mem_addr);
                    if (mem_if.mem_we) begin
                        for (int i = 0; i < 8; i++)
                            if (mem_if.mem_wstrb[i]) word[8*i +: 8] = mem_if.mem_wdata[8*i +: 8];
                        phys_mem[mem_if.mem_addr] = word;
                    end else begin
                        mem_if.mem_rdata = word;
                    end
                end
                ncyc++;
                @(posedge clk); #1;
            end
            if (wrx && !tmo)
                for (int i = 0; i < sz; i++) ref_mem[a + 64'(i)] = d[8*i +: 8];
            set_idle_exp();
            exp_berr = tmo;
            exp_dout = (wrx || tmo) ? 64'h0 : model_load(rd, a);
            mem_if.mem_ack   = 1'($urandom_range(0, 1));
            mem_if.mem_rdata = {$urandom, $urandom};
            ncyc++;
            @(posedge clk); #1;
        end
        mem_if.mem_ack = 1'b0;
        dm_rd_ctrl = 3'd0; dm_wr_ctrl = 3'd0;
        set_idle_exp();
    endtask

    initial begin
        int          n, n2;
        logic [2:0]  rd, wr;
        logic [63:0] a, d;
        int          ack_at;

        n_checks = 0; n_errors = 0;
        chk_en = 1'b0; set_idle_exp(); exp_we = 1'b0;
        exp_addr = 64'h0; exp_wstrb = 8'h0; exp_wdata = 64'h0;
        reset_obs(); last_dout = 64'h0; last_mis = 1'b0;
        last_addr = 64'h0; last_wdata = 64'h0; last_wstrb = 8'h0; last_we = 1'b0;

        // Reset held with an access presented: nothing may leave the bridge
        rst = 1'b0;
        dm_rd_ctrl = 3'd7; dm_wr_ctrl = 3'd0; dm_addr = 64'h40; dm_din = 64'h0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall",     64'(stall),             64'h0);
        check("rst_dout",      dm_dout,                64'h0);
        check("rst_mem_req",   64'(mem_if.mem_req),    64'h0);
        check("rst_mem_we",    64'(mem_if.mem_we),     64'h0);
        check("rst_mem_addr",  mem_if.mem_addr,        64'h0);
        check("rst_mem_wstrb", 64'(mem_if.mem_wstrb),  64'h0);
        check("rst_mem_wdata", mem_if.mem_wdata,       64'h0);
        check("rst_bus_err",   64'(bus_err),           64'h0);
        dm_rd_ctrl = 3'd0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // SB into byte lane 3
        reset_obs();
        do_access(3'd0, 3'd1, 64'h1003, 64'hAB, 1, n);
        check("sb_addr",  last_addr,         64'h1000);
        check("sb_wstrb", 64'(last_wstrb),   64'h08);
        check("sb_wdata", last_wdata,        64'hABAB_ABAB_ABAB_ABAB);
        check("sb_we",    64'(last_we),      64'h1);
        check("sb_stall_cycles", 64'(stall_cnt), 64'd2);

        // LB sign-extends, LBU zero-extends byte 5
        preload(64'h2000, 64'h0000_80FF_0000_0000);
        do_access(3'd1, 3'd0, 64'h2005, 64'h0, 1, n);
        check("lb_dout",  last_dout, 64'hFFFF_FFFF_FFFF_FF80);
        do_access(3'd2, 3'd0, 64'h2005, 64'h0, 2, n);
        check("lbu_dout", last_dout, 64'h0000_0000_0000_0080);

        // Misaligned LW retires immediately without a request
        reset_obs();
        do_access(3'd5, 3'd0, 64'h3002, 64'h0, 1, n);
        check("lw_mis_flag",  64'(last_mis),  64'h1);
        check("lw_mis_stall", 64'(stall_cnt), 64'h0);
        check("lw_mis_req",   64'(req_cnt),   64'h0);
        check("lw_mis_dout",  last_dout,      64'h0);

        // Timeout: request for TO cycles, single bus_err pulse, zero data
        reset_obs();
        do_access(3'd7, 3'd0, 64'h4000, 64'h0, 0, n);
        check("to_req_cycles", 64'(req_cnt),  64'(TO));
        check("to_berr_pulse", 64'(berr_cnt), 64'h1);
        check("to_dout",       last_dout,     64'h0);
        check("to_latency",    64'(n),        64'(TO + 2));

        // Asynchronous reset in the middle of BUSY
        chk_en = 1'b0;
        dm_rd_ctrl = 3'd7; dm_addr = 64'h5000;
        @(posedge clk); #1;
        check("rstb_req_before", 64'(mem_if.mem_req), 64'h1);
        #2 rst = 1'b0;
        #1;
        check("rstb_req_async",   64'(mem_if.mem_req), 64'h0);
        check("rstb_stall_async", 64'(stall),          64'h0);
        check("rstb_dout_async",  dm_dout,             64'h0);
        @(posedge clk); #1;
        dm_rd_ctrl = 3'd0;
        rst = 1'b1;
        mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 64'hDEAD_BEEF_0BAD_F00D;
        @(posedge clk); #1;
        mem_if.mem_ack = 1'b0;
        check("rstb_late_ack_req",  64'(mem_if.mem_req), 64'h0);
        check("rstb_late_ack_stl",  64'(stall),          64'h0);
        check("rstb_late_ack_berr", 64'(bus_err),        64'h0);
        set_idle_exp();
        chk_en = 1'b1;

        // Back-to-back SD then LD at the same address
        do_access(3'd0, 3'd4, 64'h10, 64'h0123_4567_89AB_CDEF, 1, n);
        do_access(3'd7, 3'd0, 64'h10, 64'h0, 1, n2);
        check("sd_ld_dout",   last_dout,   64'h0123_4567_89AB_CDEF);
        check("sd_ld_cycles", 64'(n + n2), 64'd6);

        // Randomized traffic over a small window so loads hit earlier stores
        for (int t = 0; t < 300; t++) begin
            rd = 3'($urandom_range(0, 7));
            wr = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            a  = 64'h100 + 64'($urandom_range(0, 63));
            d  = {$urandom, $urandom};
            ack_at = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO));
            do_access(rd, wr, a, d, ack_at, n);
        end

        chk_en = 1'b0;
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
